reg_file_wb: RTL and testbench
==============================

// Module: reg_file_wb
// PURPOSE
//   32-entry general register file of the multi-cycle CPU: write-back consumer of the 5-bit
//   destination-register select (rt / rd / $31). Decodes the write address into per-register
//   enables, provides two asynchronous read ports for the operand latches, and a scanning debug
//   port that steps through all registers for the board display. Register $0 reads zero always.
// PARAMETERS
//   DATA_W    32  register width in bits
//   BYPASS    0   1: a read port addressing the register being written this cycle returns wd
//   SCAN_DIV  16  clock cycles per debug-scan step (>=1)
// PORTS
//   clk        in   1       system clock, all state updates on rising edge
//   rst_n      in   1       asynchronous active-low reset
//   we         in   1       write enable (RegWrite from control FSM, asserted in WB state)
//   wa         in   5       write address (output of destination-register select)
//   wd         in   DATA_W  write data (ALUOut / MDR / PC+4 select)
//   ra1        in   5       read address A (rs)
//   rd1        out  DATA_W  read data A
//   ra2        in   5       read address B (rt)
//   rd2        out  DATA_W  read data B
//   dbg_freeze in   1       1: hold the debug scan index
//   dbg_sel    in   1       1: debug index taken from dbg_addr instead of scan counter
//   dbg_addr   in   5       manual debug index
//   dbg_idx    out  5       index currently shown on debug port
//   dbg_data   out  DATA_W  contents of register dbg_idx
//   wb_cnt     out  16      count of committed (non-$0) writes, wraps at 16'hFFFF -> 0
//   last_wa    out  5       address of the most recent committed write
// BEHAVIOUR
//   Reset (rst_n=0, async): regs[0..31]=0, scan counter=0, divider=0, wb_cnt=0, last_wa=0.
//     Hence rd1=rd2=dbg_data=0, dbg_idx=0 (dbg_sel=0) during and after reset.
//     A write pending in the cycle reset asserts is discarded; no partial update.
//   Write: on posedge clk with we=1 and wa!=0: regs[wa]<=wd, wb_cnt<=wb_cnt+1, last_wa<=wa.
//     Address decode is one-hot over 31 enables ($1..$31); exactly one register changes.
//     we=1, wa=0: no register, wb_cnt or last_wa change (write silently dropped).
//     we=0: no state change regardless of wa/wd (X on wa/wd tolerated).
//   Read: rd1=(ra1==0)?0:regs[ra1], rd2 likewise; purely combinational, zero latency.
//     Same-cycle read of register being written: BYPASS=0 -> old value, new value visible the
//     cycle after the edge; BYPASS=1 -> wd when we=1 && wa==ra && ra!=0.
//     ra1==ra2 legal; both ports return identical data.
//   Debug scan: divider counts 0..SCAN_DIV-1 each cycle; at terminal count, if dbg_freeze=0,
//     scan index increments, 31 -> 0 wrap. dbg_freeze=1 stops index and divider (both hold).
//     dbg_idx = dbg_sel ? dbg_addr : scan index; dbg_data = regs[dbg_idx] (0 for index 0),
//     combinational, no bypass. dbg_sel switching does not disturb the scan counter.
//   Width rules: DATA_W affects data only; addresses fixed at 5 bits; wb_cnt modulo 2^16.
//   No handshake: caller guarantees we is a single-cycle pulse per WB state; back-to-back
//     we cycles are each committed independently.
// TESTING
//   Reset: drive writes, pulse rst_n low mid-cycle -> all rd/dbg outputs 0 immediately, wb_cnt=0.
//   Write/read: we=1 wa=5 wd=32'hDEADBEEF, next cycle ra1=5 -> rd1=32'hDEADBEEF, wb_cnt=1, last_wa=5.
//   $0 guard: we=1 wa=0 wd=32'hFFFFFFFF -> rd1(ra1=0)=0, wb_cnt and last_wa unchanged.
//   Same-cycle RAW: wa=ra2=31 wd=32'h1234 -> BYPASS=0 rd2 old value that cycle; BYPASS=1 rd2=32'h1234.
//   Decode sweep: write i+1 to every $i, read all via both ports -> each holds i+1, no aliasing.
//   Debug scan: SCAN_DIV=2, idle 64 cycles -> dbg_idx 0..31 then wraps to 0; freeze holds; dbg_sel=1,
//     dbg_addr=7 -> dbg_data=regs[7].

Source files
------------

// File: rtl/reg_file_wb_if.sv
// reg_file_wb_if: write-back, read and debug-scan signals of the CPU register file
interface reg_file_wb_if #(parameter int DATA_W = 32);
  logic              we;
  logic [4:0]        wa;
  logic [DATA_W-1:0] wd;
  logic [4:0]        ra1;
  logic [DATA_W-1:0] rd1;
  logic [4:0]        ra2;
  logic [DATA_W-1:0] rd2;
  logic              dbg_freeze;
  logic              dbg_sel;
  logic [4:0]        dbg_addr;
  logic [4:0]        dbg_idx;
  logic [DATA_W-1:0] dbg_data;
  logic [15:0]       wb_cnt;
  logic [4:0]        last_wa;
  modport master (
    output we, wa, wd, ra1, ra2, dbg_freeze, dbg_sel, dbg_addr,
    input  rd1, rd2, dbg_idx, dbg_data, wb_cnt, last_wa
  );
  modport slave (
    input  we, wa, wd, ra1, ra2, dbg_freeze, dbg_sel, dbg_addr,
    output rd1, rd2, dbg_idx, dbg_data, wb_cnt, last_wa
  );
endinterface

// File: rtl/reg_file_wb.sv
// reg_file_wb: 32x DATA_W register file with two async read ports, $0 hardwired zero and a scanning debug port
module reg_file_wb #(
  parameter int DATA_W   = 32,
  parameter bit BYPASS   = 1'b0,
  parameter int SCAN_DIV = 16
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_wb_if.slave bus
);
  logic [DATA_W-1:0] regs [32];
  logic [31:0]       en;
  logic [15:0]       div;
  logic [4:0]        scan;
  logic [15:0]       cnt;
  logic [4:0]        last;
  logic              tc;
  assign en = (bus.we && bus.wa != 5'd0) ? (32'd1 << bus.wa) : 32'd0;
  assign tc = div == 16'(SCAN_DIV - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) regs[k] <= '0;
      div  <= '0;
      scan <= '0;
      cnt  <= '0;
      last <= '0;
    end else begin
      for (int k = 1; k < 32; k++) if (en[k]) regs[k] <= bus.wd;
      if (|en) begin
        cnt  <= cnt + 16'd1;
        last <= bus.wa;
      end
      if (!bus.dbg_freeze) begin
        div <= tc ? 16'd0 : div + 16'd1;
        if (tc) scan <= scan + 5'd1;
      end
    end
  end
  // bypass forwards the in-flight write to a port that addresses the same register
  assign bus.rd1 = (BYPASS && bus.we && bus.wa == bus.ra1 && bus.ra1 != 5'd0) ? bus.wd
                 : (bus.ra1 == 5'd0 ? '0 : regs[bus.ra1]);
  assign bus.rd2 = (BYPASS && bus.we && bus.wa == bus.ra2 && bus.ra2 != 5'd0) ? bus.wd
                 : (bus.ra2 == 5'd0 ? '0 : regs[bus.ra2]);
  assign bus.dbg_idx  = bus.dbg_sel ? bus.dbg_addr : scan;
  assign bus.dbg_data = bus.dbg_idx == 5'd0 ? '0 : regs[bus.dbg_idx];
  assign bus.wb_cnt   = cnt;
  assign bus.last_wa  = last;
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed scoreboard bench for reg_file_wb, BYPASS=0 and BYPASS=1 instances in lockstep
module tb_reg_file_wb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  reg_file_wb_if #(.DATA_W(32)) b0 ();
  reg_file_wb_if #(.DATA_W(32)) b1 ();
  assign b1.we = b0.we;
  assign b1.wa = b0.wa;
  assign b1.wd = b0.wd;
  assign b1.ra1 = b0.ra1;
  assign b1.ra2 = b0.ra2;
  assign b1.dbg_freeze = b0.dbg_freeze;
  assign b1.dbg_sel = b0.dbg_sel;
  assign b1.dbg_addr = b0.dbg_addr;
  reg_file_wb #(.DATA_W(32), .BYPASS(1'b0), .SCAN_DIV(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  reg_file_wb #(.DATA_W(32), .BYPASS(1'b1), .SCAN_DIV(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int fr_idx;
  task automatic push(input string t, input logic [31:0] v);
    sbq.push_back('{t, v});
  endtask
  task automatic chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $error("FAIL sb_empty obs=%h exp=none", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.val);
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    b0.we = 1'b0; b0.wa = '0; b0.wd = '0; b0.ra1 = 5'd5; b0.ra2 = 5'd31;
    b0.dbg_freeze = 1'b1; b0.dbg_sel = 1'b0; b0.dbg_addr = '0;
    tick(); tick();
    rst_n = 1'b1;
    push("rst_rd1", 0); push("rst_rd2", 0); push("rst_idx", 0);
    push("rst_dbg", 0); push("rst_cnt", 0); push("rst_last", 0);
    #1;
    chk(b0.rd1); chk(b0.rd2); chk(32'(b0.dbg_idx));
    chk(b0.dbg_data); chk(32'(b0.wb_cnt)); chk(32'(b0.last_wa));
    b0.we = 1'b1; b0.wa = 5'd5; b0.wd = 32'hDEADBEEF;
    tick();
    b0.we = 1'b0; b0.ra1 = 5'd5;
    push("wr_rd1", 32'hDEADBEEF); push("wr_cnt", 1); push("wr_last", 5);
    #1;
    chk(b0.rd1); chk(32'(b0.wb_cnt)); chk(32'(b0.last_wa));
    b0.we = 1'b1; b0.wa = 5'd0; b0.wd = 32'hFFFFFFFF;
    tick();
    b0.we = 1'b0; b0.ra1 = 5'd0;
    push("z_rd1", 0); push("z_cnt", 1); push("z_last", 5);
    #1;
    chk(b0.rd1); chk(32'(b0.wb_cnt)); chk(32'(b0.last_wa));
    b0.we = 1'b1; b0.wa = 5'd31; b0.wd = 32'h0000AAAA;
    tick();
    b0.wd = 32'h00001234; b0.ra2 = 5'd31;
    push("raw_old_b0", 32'h0000AAAA); push("raw_byp_b1", 32'h00001234);
    #1;
    chk(b0.rd2); chk(b1.rd2);
    tick();
    b0.we = 1'b0; b0.wa = 5'bx; b0.wd = 'x;
    push("raw_new_b0", 32'h00001234); push("raw_new_b1", 32'h00001234);
    #1;
    chk(b0.rd2); chk(b1.rd2);
    tick();
    push("wex_cnt", 3); push("wex_rd2", 32'h00001234);
    #1;
    chk(32'(b0.wb_cnt)); chk(b0.rd2);
    for (int i = 1; i < 32; i++) begin
      b0.we = 1'b1; b0.wa = 5'(i); b0.wd = 32'(i + 1);
      tick();
    end
    b0.we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      b0.ra1 = 5'(i); b0.ra2 = 5'(31 - i);
      push($sformatf("sw_rd1_%0d", i), i == 0 ? 0 : 32'(i + 1));
      push($sformatf("sw_rd2_%0d", 31 - i), i == 31 ? 0 : 32'(32 - i));
      #1;
      chk(b0.rd1); chk(b0.rd2);
    end
    push("sw_cnt", 34); push("sw_last", 31);
    chk(32'(b0.wb_cnt)); chk(32'(b0.last_wa));
    tick();
    b0.we = 1'b1; b0.wa = 5'd9; b0.wd = 32'hCAFEF00D;
    b0.ra1 = 5'd5; b0.ra2 = 5'd31; b0.dbg_sel = 1'b1; b0.dbg_addr = 5'd7;
    push("pre_rst_rd1", 6);
    #1;
    chk(b0.rd1);
    #2;
    rst_n = 1'b0;
    push("ar_rd1", 0); push("ar_rd2", 0); push("ar_dbg", 0); push("ar_cnt", 0);
    #1;
    chk(b0.rd1); chk(b0.rd2); chk(b0.dbg_data); chk(32'(b0.wb_cnt));
    tick();
    rst_n = 1'b1; b0.we = 1'b0; b0.ra1 = 5'd9; b0.dbg_sel = 1'b0;
    push("ar_rd9", 0); push("ar_cnt2", 0); push("ar_last", 0); push("ar_idx", 0);
    #1;
    chk(b0.rd1); chk(32'(b0.wb_cnt)); chk(32'(b0.last_wa)); chk(32'(b0.dbg_idx));
    b0.we = 1'b1; b0.wa = 5'd7; b0.wd = 32'h00000077;
    tick();
    b0.we = 1'b0; b0.dbg_freeze = 1'b0;
    for (int k = 1; k <= 66; k++) begin
      tick();
      push($sformatf("scan_idx_%0d", k), (k / 2) % 32);
      push($sformatf("scan_dat_%0d", k), ((k / 2) % 32) == 7 ? 32'h77 : 0);
      #1;
      chk(32'(b0.dbg_idx)); chk(b0.dbg_data);
    end
    b0.dbg_freeze = 1'b1;
    fr_idx = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      push("frz_idx", 32'(fr_idx));
      chk(32'(b0.dbg_idx));
    end
    b0.dbg_sel = 1'b1; b0.dbg_addr = 5'd7;
    push("sel_idx", 7); push("sel_dat", 32'h77);
    #1;
    chk(32'(b0.dbg_idx)); chk(b0.dbg_data);
    b0.dbg_sel = 1'b0;
    push("unsel_idx", 32'(fr_idx));
    #1;
    chk(32'(b0.dbg_idx));
    b0.dbg_freeze = 1'b0;
    tick(); tick();
    push("resume_idx", 2);
    chk(32'(b0.dbg_idx));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
